// File: rtl/vga_pkg.sv
// VGA scan-out shared definitions: 640x480@60 timing defaults,
// line/frame total helpers and colour field sizing.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_PIX_W    = 24;

    function automatic int h_total(input int act, input int fp,
                                   input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int v_total(input int act, input int fp,
                                   input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int col_w(input int pix_w);
        return pix_w / 3;
    endfunction

endpackage

// File: rtl/vga_fb_ram.sv
// Framebuffer storage: one write port, one registered read port,
// both banks in a single array.
module vga_fb_ram
  import vga_pkg::*;
#(
  parameter int    DW        = DEF_PIX_W,
  parameter int    DEPTH     = 2,
  parameter int    AW        = 1,
  parameter string INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/vga_fb_display.sv
// VGA timing generator with double-buffered framebuffer scan-out,
// frame-boundary bank swap and vertical scroll.
module vga_fb_display
    import vga_pkg::*;
#(
    parameter int    H_ACTIVE    = DEF_H_ACTIVE,
    parameter int    H_FP        = DEF_H_FP,
    parameter int    H_SYNC      = DEF_H_SYNC,
    parameter int    H_BP        = DEF_H_BP,
    parameter int    V_ACTIVE    = DEF_V_ACTIVE,
    parameter int    V_FP        = DEF_V_FP,
    parameter int    V_SYNC      = DEF_V_SYNC,
    parameter int    V_BP        = DEF_V_BP,
    parameter bit    SYNC_POL    = 1'b0,
    parameter int    PIX_W       = DEF_PIX_W,
    parameter int    SCALE_SHIFT = 0,
    parameter string INIT_FILE   = "",
    localparam int   FB_COLS     = H_ACTIVE >> SCALE_SHIFT,
    localparam int   FB_ROWS     = V_ACTIVE >> SCALE_SHIFT,
    localparam int   AW          = $clog2(FB_COLS * FB_ROWS),
    localparam int   SW          = $clog2(FB_ROWS),
    localparam int   CW          = col_w(PIX_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [AW-1:0]    wr_addr,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             swap_req,
    output logic             swap_done,
    input  logic [SW-1:0]    scroll_y,
    output logic             front_bank,
    output logic             frame_start,
    output logic             hsync,
    output logic             vsync,
    output logic             blank_n,
    output logic [CW-1:0]    vga_r,
    output logic [CW-1:0]    vga_g,
    output logic [CW-1:0]    vga_b
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int FB_SIZE = FB_COLS * FB_ROWS;
    localparam int RAW     = $clog2(2 * FB_SIZE);

    logic [HW-1:0]    h_cnt;
    logic [VW-1:0]    v_cnt;
    logic             front_q;
    logic             swap_pend;
    logic [SW-1:0]    scroll_lat;
    logic [SW-1:0]    scroll_ok;
    logic [SW-1:0]    scroll_eff;
    logic [SW:0]      row_sum;
    logic [RAW-1:0]   rd_addr;
    logic [RAW-1:0]   wr_full;
    logic             wr_en;
    logic             swap_now;
    logic             active;
    logic             hs_on;
    logic             vs_on;
    logic             act_d1;
    logic             hs_d1;
    logic             vs_d1;
    logic [PIX_W-1:0] rd_data;
    logic [PIX_W-1:0] rgb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == HW'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign frame_start = !rst && (h_cnt == '0) && (v_cnt == '0);
    assign swap_now    = swap_pend && (h_cnt == '0)
                         && (v_cnt == VW'(V_ACTIVE));
    assign swap_done   = swap_now;
    assign wr_ready    = !swap_pend;
    assign front_bank  = front_q;

    // Out-of-range offsets fall back to no scroll.
    assign scroll_ok  = ({1'b0, scroll_y} < (SW+1)'(FB_ROWS))
                        ? scroll_y : '0;
    assign scroll_eff = frame_start ? scroll_ok : scroll_lat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            front_q    <= 1'b0;
            swap_pend  <= 1'b0;
            scroll_lat <= '0;
        end else begin
            if (frame_start) scroll_lat <= scroll_ok;
            if (swap_now) begin
                front_q   <= ~front_q;
                swap_pend <= swap_req;
            end else if (swap_req) begin
                swap_pend <= 1'b1;
            end
        end
    end

    assign active = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    assign hs_on  = (h_cnt >= HW'(H_ACTIVE + H_FP))
                    && (h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_on  = (v_cnt >= VW'(V_ACTIVE + V_FP))
                    && (v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC));

    always_comb begin
        row_sum = (SW+1)'(v_cnt >> SCALE_SHIFT) + {1'b0, scroll_eff};
        if (row_sum >= (SW+1)'(FB_ROWS))
            row_sum = row_sum - (SW+1)'(FB_ROWS);
        rd_addr = (front_q ? RAW'(FB_SIZE) : '0)
                  + RAW'(row_sum) * RAW'(FB_COLS)
                  + RAW'(h_cnt >> SCALE_SHIFT);
    end

    // Host always targets the bank not being shown.
    assign wr_full = (front_q ? '0 : RAW'(FB_SIZE)) + RAW'(wr_addr);
    assign wr_en   = wr_valid && !swap_pend
                     && ({1'b0, wr_addr} < (AW+1)'(FB_SIZE));

    vga_fb_ram #(
        .DW       (PIX_W),
        .DEPTH    (2 * FB_SIZE),
        .AW       (RAW),
        .INIT_FILE(INIT_FILE)
    ) u_ram (
        .clk  (clk),
        .we   (wr_en),
        .waddr(wr_full),
        .wdata(wr_data),
        .re   (active),
        .raddr(rd_addr),
        .rdata(rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_d1  <= 1'b0;
            hs_d1   <= ~SYNC_POL;
            vs_d1   <= ~SYNC_POL;
            blank_n <= 1'b0;
            hsync   <= ~SYNC_POL;
            vsync   <= ~SYNC_POL;
            rgb_q   <= '0;
        end else begin
            act_d1  <= active;
            hs_d1   <= hs_on ? SYNC_POL : ~SYNC_POL;
            vs_d1   <= vs_on ? SYNC_POL : ~SYNC_POL;
            blank_n <= act_d1;
            hsync   <= hs_d1;
            vsync   <= vs_d1;
            rgb_q   <= act_d1 ? rd_data : '0;
        end
    end

    assign vga_r = rgb_q[PIX_W-1 -: CW];
    assign vga_g = rgb_q[2*CW-1 -: CW];
    assign vga_b = rgb_q[CW-1:0];

endmodule

// File: tb/tb_vga_fb_display.sv
// Bench for vga_fb_display on a reduced 16x12 raster, 2x pixel scale,
// with a reference model feeding a per-cycle output scoreboard.
module tb_vga_fb_display;

    localparam int HA = 16, HF = 2, HS = 4, HB = 2, HT = 24;
    localparam int VA = 12, VF = 1, VS = 2, VB = 1, VT = 16;
    localparam int COLS = 8, ROWS = 6, FBS = 48;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [5:0]  wr_addr = '0;
    logic [23:0] wr_data = '0;
    logic        swap_req = 1'b0;
    logic        swap_done;
    logic [2:0]  scroll_y = '0;
    logic        front_bank;
    logic        frame_start;
    logic        hsync, vsync, blank_n;
    logic [7:0]  vga_r, vga_g, vga_b;

    vga_fb_display #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0), .PIX_W(24), .SCALE_SHIFT(1), .INIT_FILE("")
    ) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .swap_req(swap_req), .swap_done(swap_done),
        .scroll_y(scroll_y), .front_bank(front_bank),
        .frame_start(frame_start),
        .hsync(hsync), .vsync(vsync), .blank_n(blank_n),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        bl;
        logic [23:0] rgb;
        logic        known;
    } exp_t;

    localparam exp_t RST_E = '{hs: 1'b1, vs: 1'b1, bl: 1'b0,
                               rgb: 24'h0, known: 1'b1};

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_rgb = 0;
    int          m_h = 0, m_v = 0, m_scroll = 0;
    bit          m_front = 1'b0, m_pend = 1'b0;
    logic [23:0] m_mem[2][FBS];
    bit          m_known[2][FBS];

    function automatic int san(input logic [2:0] s);
        return (int'(s) >= ROWS) ? 0 : int'(s);
    endfunction

    function automatic logic [23:0] pat(input int b, input int a);
        logic [7:0] r, g, bb;
        r  = 8'(a * 7 + b * 3 + 1);
        g  = 8'(a) ^ 8'h5A;
        bb = b ? 8'hC3 : 8'h3C;
        return {r, g, bb};
    endfunction

    // Reference model state advances on the same edge as the design.
    always @(posedge clk) begin
        if (rst) begin
            m_h      <= 0;
            m_v      <= 0;
            m_front  <= 1'b0;
            m_pend   <= 1'b0;
            m_scroll <= 0;
            q.delete();
            q.push_back(RST_E);
            q.push_back(RST_E);
        end else begin
            if (wr_valid && !m_pend && int'(wr_addr) < FBS) begin
                m_mem[int'(!m_front)][int'(wr_addr)]   <= wr_data;
                m_known[int'(!m_front)][int'(wr_addr)] <= 1'b1;
            end
            if (m_h == 0 && m_v == 0) m_scroll <= san(scroll_y);
            if (m_pend && m_h == 0 && m_v == VA) begin
                m_front <= !m_front;
                m_pend  <= swap_req;
            end else if (swap_req) begin
                m_pend <= 1'b1;
            end
            if (m_h == HT - 1) begin
                m_h <= 0;
                m_v <= (m_v == VT - 1) ? 0 : m_v + 1;
            end else begin
                m_h <= m_h + 1;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e, n;
        int eff, row, idx;
        if (!rst) begin
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_empty got=0 entries exp>0");
            end else begin
                e = q.pop_front();
                if ({hsync, vsync, blank_n} !== {e.hs, e.vs, e.bl}) begin
                    n_fail++;
                    if (n_fail <= 30)
                        $display("FAIL sync_blank t=%0t got=%b exp=%b",
                                 $time, {hsync, vsync, blank_n},
                                 {e.hs, e.vs, e.bl});
                end
                if (e.known) begin
                    n_checks++;
                    n_rgb++;
                    if ({vga_r, vga_g, vga_b} !== e.rgb) begin
                        n_fail++;
                        if (n_fail <= 30)
                            $display("FAIL rgb t=%0t got=%h exp=%h",
                                     $time, {vga_r, vga_g, vga_b}, e.rgb);
                    end
                end
            end
            n_checks++;
            if ({frame_start, wr_ready, swap_done, front_bank} !==
                {(m_h == 0 && m_v == 0), !m_pend,
                 (m_pend && m_h == 0 && m_v == VA), m_front}) begin
                n_fail++;
                if (n_fail <= 30)
                    $display("FAIL ctrl t=%0t got=%b exp=%b", $time,
                             {frame_start, wr_ready, swap_done, front_bank},
                             {(m_h == 0 && m_v == 0), !m_pend,
                              (m_pend && m_h == 0 && m_v == VA), m_front});
            end
            n.hs = !(m_h >= HA + HF && m_h < HA + HF + HS);
            n.vs = !(m_v >= VA + VF && m_v < VA + VF + VS);
            n.bl = (m_h < HA) && (m_v < VA);
            if (n.bl) begin
                eff = (m_h == 0 && m_v == 0) ? san(scroll_y) : m_scroll;
                row = (m_v >> 1) + eff;
                if (row >= ROWS) row -= ROWS;
                idx = row * COLS + (m_h >> 1);
                n.rgb   = m_mem[int'(m_front)][idx];
                n.known = m_known[int'(m_front)][idx];
            end else begin
                n.rgb   = 24'h0;
                n.known = 1'b1;
            end
            q.push_back(n);
        end
    end

    task automatic do_write(input int a, input logic [23:0] d,
                            output int waited);
        waited = 0;
        @(posedge clk); #1;
        wr_valid = 1'b1;
        wr_addr  = 6'(a);
        wr_data  = d;
        @(negedge clk);
        while (wr_ready !== 1'b1 && waited < 2 * FRAME) begin
            waited++;
            @(negedge clk);
        end
        if (wr_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL wr_timeout got=wr_ready=%b exp=1", wr_ready);
        end
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic fill_back();
        int w;
        int b;
        for (int a = 0; a < FBS; a++) begin
            b = int'(!m_front);
            do_write(a, pat(b, a), w);
        end
    endtask

    task automatic pulse_swap();
        @(posedge clk); #1;
        swap_req = 1'b1;
        @(posedge clk); #1;
        swap_req = 1'b0;
    endtask

    task automatic wait_fs();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_start !== 1'b1 && n < 2 * FRAME);
        n_checks++;
        if (frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL fs_timeout got=%b exp=1", frame_start);
        end
    endtask

    task automatic wait_swap();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (swap_done !== 1'b1 && n < 3 * FRAME);
        n_checks++;
        if (swap_done !== 1'b1 || m_h != 0 || m_v != VA) begin
            n_fail++;
            $display("FAIL swap_pos got=%b@(%0d,%0d) exp=1@(0,%0d)",
                     swap_done, m_h, m_v, VA);
        end
    endtask

    task automatic test_reset();
        int n;
        logic hp;
        bit fall;
        pulse_swap();
        repeat (37) @(posedge clk);
        #1 rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            n_checks++;
            if ({hsync, vsync, blank_n, vga_r, vga_g, vga_b, wr_ready,
                 swap_done, frame_start, front_bank} !==
                {3'b110, 24'h0, 4'b1000}) begin
                n_fail++;
                $display("FAIL reset_state got=%h exp=%h",
                         {hsync, vsync, blank_n, vga_r, vga_g, vga_b,
                          wr_ready, swap_done, frame_start, front_bank},
                         {3'b110, 24'h0, 4'b1000});
            end
        end
        @(posedge clk); #1 rst = 1'b0;
        n = 0;
        @(negedge clk);
        while (hsync !== 1'b0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        n_checks++;
        if (n != HA + HF + 2) begin
            n_fail++;
            $display("FAIL hsync_first_fall got=%0d exp=%0d", n, HA + HF + 2);
        end
        hp = hsync;
        n = 0;
        fall = 1'b0;
        while (!fall && n < 200) begin
            @(negedge clk);
            n++;
            fall = hp && !hsync;
            hp = hsync;
        end
        n_checks++;
        if (n != HT) begin
            n_fail++;
            $display("FAIL line_period got=%0d exp=%0d", n, HT);
        end
    endtask

    task automatic test_frame();
        int fs = 0, vl = 0, lines = 0;
        logic hp;
        wait_fs();
        hp = hsync;
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (frame_start) fs++;
            if (!vsync) vl++;
            if (hp && !hsync) lines++;
            hp = hsync;
            @(negedge clk);
        end
        n_checks++;
        if (fs != 3 || vl != 3 * VS * HT || lines != 3 * VT) begin
            n_fail++;
            $display("FAIL frame_counts got=%0d/%0d/%0d exp=3/%0d/%0d",
                     fs, vl, lines, 3 * VS * HT, 3 * VT);
        end
    endtask

    task automatic test_swap_display();
        int w;
        int n = 0;
        fill_back();
        do_write(0, 24'hFF0000, w);
        while (m_v != 3 && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        pulse_swap();
        wait_swap();
        wait_fs();
        @(negedge clk);
        n_checks++;
        if (vga_r !== 8'h00 || blank_n !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early got=%h/%b exp=00/0", vga_r, blank_n);
        end
        @(negedge clk);
        n_checks++;
        if (vga_r !== 8'hFF || blank_n !== 1'b1 || front_bank !== 1'b1) begin
            n_fail++;
            $display("FAIL swap_pixel got=%h/%b/%b exp=ff/1/1",
                     vga_r, blank_n, front_bank);
        end
    endtask

    task automatic test_swap_block();
        int waited = 0;
        bit seen = 1'b0;
        fill_back();
        @(posedge clk); #1;
        swap_req = 1'b1;
        wr_valid = 1'b1;
        wr_addr  = 6'd5;
        wr_data  = 24'h123456;
        @(negedge clk);
        n_checks++;
        if (wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL same_cycle_wr got=%b exp=1", wr_ready);
        end
        @(posedge clk); #1;
        swap_req = 1'b0;
        wr_addr  = 6'd6;
        wr_data  = 24'h654321;
        @(negedge clk);
        while (wr_ready !== 1'b1 && waited < 3 * FRAME) begin
            if (swap_done) seen = 1'b1;
            waited++;
            @(negedge clk);
        end
        n_checks++;
        if (waited == 0 || !seen || wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL blocked_wr got=wait%0d/seen%0d exp=wait>0/seen1",
                     waited, seen);
        end
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        wr_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_addr = 6'(i + 8);
            wr_data = 24'hA00000 | 24'(i * 17);
            @(negedge clk);
            n_checks++;
            if (wr_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready i=%0d got=%b exp=1", i, wr_ready);
            end
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        pulse_swap();
        wait_swap();
        wait_fs();
        wait_fs();
    endtask

    task automatic test_scroll();
        logic [23:0] exp_px;
        wait_fs();
        repeat (HT * 3) @(negedge clk);
        @(posedge clk); #1 scroll_y = 3'd5;
        wait_fs();
        @(negedge clk);
        @(negedge clk);
        exp_px = m_mem[int'(m_front)][5 * COLS];
        n_checks++;
        if ({vga_r, vga_g, vga_b} !== exp_px) begin
            n_fail++;
            $display("FAIL scroll_line0 got=%h exp=%h",
                     {vga_r, vga_g, vga_b}, exp_px);
        end
        repeat (2 * HT) @(negedge clk);
        exp_px = m_mem[int'(m_front)][0];
        n_checks++;
        if ({vga_r, vga_g, vga_b} !== exp_px) begin
            n_fail++;
            $display("FAIL scroll_wrap got=%h exp=%h",
                     {vga_r, vga_g, vga_b}, exp_px);
        end
        @(posedge clk); #1 scroll_y = 3'd7;
        wait_fs();
        @(negedge clk);
        @(negedge clk);
        exp_px = m_mem[int'(m_front)][0];
        n_checks++;
        if ({vga_r, vga_g, vga_b} !== exp_px) begin
            n_fail++;
            $display("FAIL scroll_oor got=%h exp=%h",
                     {vga_r, vga_g, vga_b}, exp_px);
        end
        repeat (HT * 4) @(negedge clk);
        @(posedge clk); #1 scroll_y = 3'd3;
        wait_fs();
        @(negedge clk);
        @(negedge clk);
        exp_px = m_mem[int'(m_front)][3 * COLS];
        n_checks++;
        if ({vga_r, vga_g, vga_b} !== exp_px) begin
            n_fail++;
            $display("FAIL scroll_next got=%h exp=%h",
                     {vga_r, vga_g, vga_b}, exp_px);
        end
    endtask

    task automatic test_oob();
        int w;
        do_write(FBS, 24'hABCDEF, w);
        n_checks++;
        if (w != 0) begin
            n_fail++;
            $display("FAIL oob_handshake got=wait%0d exp=wait0", w);
        end
        pulse_swap();
        wait_swap();
        wait_fs();
        wait_fs();
        pulse_swap();
        wait_swap();
        wait_fs();
        wait_fs();
    endtask

    initial begin
        #(80000 * 10);
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_frame();
        test_swap_display();
        test_swap_block();
        test_back_to_back();
        test_scroll();
        test_oob();
        n_checks++;
        if (n_rgb < 2000) begin
            n_fail++;
            $display("FAIL rgb_coverage got=%0d exp>=2000", n_rgb);
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
